exe_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EXE stage, directly downstream of the ID stage register.
- Consumes decoded operands, op select and destination tag from ID/EXE, and computes one MUL/MULH/DIV/REM result over multiple cycles.
- Holds the front end via stall_out while busy, the same stall path that freezes the ID/EXE register.
- Hands the result to EXE/MEM with a one-cycle done/wb_en pulse.

---
 rtl/exe_muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative signed multiply/divide unit for the EXE stage.
// Runs one shift-add (MUL/MULH) or restoring shift-subtract (DIV/REM) step per
// cycle on operand magnitudes, then applies the sign correction in a FIX cycle.
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   branch_taken      flush: aborts an operation in CALC/FIX and blocks accept in IDLE
//   start, op         request and operation (00 MUL, 01 MULH, 10 DIV, 11 REM)
//   src_a, src_b      operand A / dividend, operand B / divisor
//   dest_in           destination register tag
//   stall_out         combinational hold for ID/EXE and upstream stages
//   busy              registered, high in CALC and FIX
//   done, wb_en       one-cycle result-valid / write-back pulse
//   dest, result      destination tag and result word, held until the next result
//
// Build option: define MULDIV_EARLY_OUT_EN to send zero-operand cases straight
// from IDLE to DONE. Without it every operation takes WIDTH+3 cycles.
module exe_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       dest_in,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic             wb_en,
  output logic [4:0]       dest,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [4:0]         r_dest;
  logic [4:0]         r_dest_lat;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_hi;   // product high word / partial remainder
  logic [WIDTH-1:0]   r_lo;   // multiplier then product low / dividend then quotient
  logic [WIDTH-1:0]   r_b;    // |src_b|: multiplicand or divisor

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_dtrial;
  logic               w_dneg;
  logic [PW-1:0]      w_prod;
  logic [PW-1:0]      w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic               w_bzero;
  logic [WIDTH-1:0]   w_fix_result;
  logic               w_early;
  logic [WIDTH-1:0]   w_early_result;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly 2^(WIDTH-1) when read as unsigned.
  assign w_abs_a = src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
  assign w_abs_b = src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;

  // Shift-add step: add multiplicand into the high word when the multiplier LSB is set.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // Restoring divide step: bring in the next dividend bit, try to subtract.
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_dtrial = w_dshift - {1'b0, r_b};
  assign w_dneg   = w_dtrial[WIDTH];

  // Sign correction and result-word selection for the FIX cycle.
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_sign_a ^ r_sign_b) ? (~w_prod + PW'(1)) : w_prod;
  assign w_quo_s  = (r_sign_a ^ r_sign_b) ? (~r_lo + WIDTH'(1)) : r_lo;
  assign w_rem_s  = r_sign_a ? (~r_hi + WIDTH'(1)) : r_hi;
  assign w_bzero  = (r_b == '0);

  // A zero divisor leaves |a| as remainder, so REM needs no special case;
  // only the quotient is forced to all ones.
  always_comb begin
    w_fix_result = '0;
    case (r_op)
      2'b00:   w_fix_result = w_prod_s[WIDTH-1:0];
      2'b01:   w_fix_result = w_prod_s[PW-1:WIDTH];
      2'b10:   w_fix_result = w_bzero ? '1 : w_quo_s;
      default: w_fix_result = w_rem_s;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Zero-operand shortcut, evaluated on the raw inputs in the accept cycle.
  always_comb begin
    w_early        = 1'b0;
    w_early_result = '0;
    if (!op[1]) begin
      w_early = (src_a == '0) || (src_b == '0);
    end else if (src_b == '0) begin
      w_early        = 1'b1;
      w_early_result = op[0] ? src_a : '1;
    end else begin
      w_early = (src_a == '0);
    end
  end
`else
  assign w_early        = 1'b0;
  assign w_early_result = '0;
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dest     <= '0;
      r_dest_lat <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !branch_taken) begin
            r_op       <= op;
            r_sign_a   <= src_a[WIDTH-1];
            r_sign_b   <= src_b[WIDTH-1];
            r_lo       <= w_abs_a;
            r_b        <= w_abs_b;
            r_hi       <= '0;
            r_cnt      <= '0;
            r_dest_lat <= dest_in;
            if (w_early) begin
              r_result <= w_early_result;
              r_dest   <= dest_in;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (branch_taken) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_op[1]) begin
              r_hi <= w_dneg ? w_dshift[WIDTH-1:0] : w_dtrial[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], ~w_dneg};
            end else begin
              r_hi <= w_msum[WIDTH:1];
              r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (branch_taken) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_result;
            r_dest   <= r_dest_lat;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // A flush here does not cancel the pulse; the flushed stage drops it.
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall covers the accept cycle too, so ID/EXE holds the operands being latched.
  assign stall_out = r_busy | (start & (r_state == S_IDLE));
  assign busy      = r_busy;
  assign done      = r_done;
  assign wb_en     = r_done;
  assign dest      = r_dest;
  assign result    = r_result;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed testbench for exe_muldiv_unit (WIDTH = 32).
module tb_exe_muldiv_unit;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  localparam int FULL_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT   = 1;
  localparam int ZSTALL = 1;
`else
  localparam int ZLAT   = 34;
  localparam int ZSTALL = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_taken = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  dest_in = '0;
  logic        stall_out, busy, done, wb_en;
  logic [4:0]  dest;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  exe_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dest_in(dest_in), .stall_out(stall_out),
    .busy(busy), .done(done), .wb_en(wb_en), .dest(dest), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one operation and follow it until done or until max_cyc cycles pass.
  // lat counts rising edges from the accept edge to the edge that raises done.
  // br_at >= 0 raises branch_taken during the cycle following edge accept+br_at.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input int br_at, input int max_cyc,
                       output logic [31:0] res, output logic [4:0] dst, output int lat,
                       output int stalls, output logic got, output logic st_done,
                       output logic wb_done, output logic busy_aft);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; dest_in = d;
    @(negedge clk);
    stalls = stall_out ? 1 : 0;
    @(posedge clk); #1;
    // Scramble inputs after accept; the unit must work from latched copies.
    start = 1'b0; op = ~o; src_a = 32'h5A5A_1234; src_b = 32'h0F0F_0F0F; dest_in = ~d;
    lat = 0; got = 1'b0; busy_aft = 1'b1; res = '0; dst = '0; st_done = 1'b1; wb_done = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      branch_taken = (lat == br_at);
      @(negedge clk);
      if (br_at >= 0 && lat == br_at + 1) busy_aft = busy;
      if (done) begin
        got = 1'b1; res = result; dst = dest; st_done = stall_out; wb_done = wb_en;
      end else begin
        if (stall_out) stalls++;
        @(posedge clk); #1;
        lat++;
      end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, wb_en, stall_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, wb_en, stall_out});
    end
    total++;
    if (dest !== 5'd0 || result !== 32'd0) begin
      bad++; $display("FAIL reset_data got dest=%0d result=%h exp 0/0", dest, result);
    end
    rst = 1'b1;
  endtask

  task automatic test_mul;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd17, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul_7x-3 got=%h done=%b exp=ffffffeb", r, g);
    end
    total++;
    if (lat !== FULL_LAT) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", lat, FULL_LAT); end
    total++;
    if (st !== 34 || sd !== 1'b0) begin
      bad++; $display("FAIL mul_stall got cycles=%0d at_done=%b exp 34/0", st, sd);
    end
    total++;
    if (d !== 5'd17 || wd !== 1'b1) begin
      bad++; $display("FAIL dest_wb got dest=%0d wb_en=%b exp 17/1", d, wd);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || wb_en !== 1'b0) begin
      bad++; $display("FAIL done_pulse got done=%b wb_en=%b exp 0/0", done, wb_en);
    end
    do_op(OP_MUL, 32'h1234_5678, 32'h10, 5'd1, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'h2345_6780) begin bad++; $display("FAIL mul_shift got=%h exp=23456780", r); end
    do_op(OP_MUL, 32'd0, 32'd5, 5'd2, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd0 || lat !== ZLAT) begin
      bad++; $display("FAIL mul_zero got=%h lat=%0d exp=0 lat=%0d", r, lat, ZLAT);
    end
  endtask

  task automatic test_mulh;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    do_op(OP_MULH, 32'h8000_0000, 32'd2, 5'd3, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_min_x2 got=%h exp=ffffffff", r); end
    do_op(OP_MULH, 32'h1234_5678, 32'h10, 5'd3, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'h0000_0001) begin bad++; $display("FAIL mulh_pos got=%h exp=00000001", r); end
    do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'h0000_0000) begin bad++; $display("FAIL mulh_m1xm1 got=%h exp=00000000", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'hFFFF_FFFD || lat !== FULL_LAT) begin
      bad++; $display("FAIL div_-7/2 got=%h lat=%0d exp=fffffffd lat=34", r, lat);
    end
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_-7/2 got=%h exp=ffffffff", r); end
    do_op(OP_DIV, 32'd100, 32'd7, 5'd4, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'd14) begin bad++; $display("FAIL div_100/7 got=%h exp=0000000e", r); end
    do_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd4, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL rem_100/-7 got=%h exp=00000002", r); end
  endtask

  task automatic test_div_corner;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    do_op(OP_DIV, 32'd5, 32'd0, 5'd6, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'hFFFF_FFFF || lat !== ZLAT || st !== ZSTALL) begin
      bad++; $display("FAIL div_by_zero got=%h lat=%0d stall=%0d exp=ffffffff lat=%0d stall=%0d",
                      r, lat, st, ZLAT, ZSTALL);
    end
    do_op(OP_REM, 32'd5, 32'd0, 5'd7, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd5 || lat !== ZLAT || d !== 5'd7) begin
      bad++; $display("FAIL rem_by_zero got=%h lat=%0d dest=%0d exp=00000005 lat=%0d dest=7",
                      r, lat, d, ZLAT);
    end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'h8000_0000 || lat !== FULL_LAT) begin
      bad++; $display("FAIL div_overflow got=%h lat=%0d exp=80000000 lat=34", r, lat);
    end
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL rem_overflow got=%h exp=00000000", r); end
    do_op(OP_DIV, 32'd0, 32'd3, 5'd6, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd0 || lat !== ZLAT) begin
      bad++; $display("FAIL div_zero_dividend got=%h lat=%0d exp=0 lat=%0d", r, lat, ZLAT);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    do_op(OP_MUL, 32'd6, 32'd7, 5'd3, -1, 60, r, d, lat, st, g, sd, wd, ba);
    // Flush in the 10th CALC cycle: no done, prior result and dest survive.
    do_op(OP_MUL, 32'd9, 32'd9, 5'd20, 9, 45, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (g !== 1'b0 || ba !== 1'b0) begin
      bad++; $display("FAIL flush_calc got done_seen=%b busy_after=%b exp 0/0", g, ba);
    end
    total++;
    if (result !== 32'd42 || dest !== 5'd3) begin
      bad++; $display("FAIL flush_hold got result=%h dest=%0d exp=0000002a dest=3", result, dest);
    end
    do_op(OP_DIV, 32'd100, 32'd7, 5'd21, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd14 || d !== 5'd21) begin
      bad++; $display("FAIL after_flush got=%h dest=%0d exp=0000000e dest=21", r, d);
    end
    // Flush in the DONE cycle must not cancel the pulse.
    do_op(OP_MUL, 32'd2, 32'd3, 5'd8, FULL_LAT - 1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd6 || lat !== FULL_LAT) begin
      bad++; $display("FAIL flush_in_done got=%h done=%b lat=%0d exp=00000006 1 34", r, g, lat);
    end
  endtask

  task automatic test_branch_idle;
    @(posedge clk); #1;
    start = 1'b1; branch_taken = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd3; dest_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL branch_idle got busy=%b stall=%b exp 0/0", busy, stall_out);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic [4:0] d; int lat, st; logic g, sd, wd, ba;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd4; dest_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, wb_en, stall_out} !== 4'b0000 || dest !== 5'd0 || result !== 32'd0) begin
      bad++; $display("FAIL reset_mid got ctrl=%b dest=%0d result=%h exp 0000/0/0",
                      {busy, done, wb_en, stall_out}, dest, result);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(OP_MUL, 32'd3, 32'd4, 5'd9, -1, 60, r, d, lat, st, g, sd, wd, ba);
    total++;
    if (!g || r !== 32'd12 || d !== 5'd9 || lat !== FULL_LAT) begin
      bad++; $display("FAIL post_reset got=%h dest=%0d lat=%0d exp=0000000c dest=9 lat=34", r, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_corner();
    test_flush();
    test_branch_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
